// File: rtl/hex_status_display.sv
`default_nettype none
// ============================================================================
// hex_status_display : seven-segment banner/hex status controller with a
// debounced mode key and heartbeat LED.                          Rev 1.0
// ============================================================================
module hex_status_display #(
  parameter int NUM_DIGITS      = 8,
  parameter int BANNER_LEN      = 16,
  parameter int TICK_DIV        = 12_500_000,
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int HEARTBEAT_DIV   = 25_000_000,
  localparam int AW = (BANNER_LEN > 1) ? $clog2(BANNER_LEN) : 1
) (
  input  logic                    clk_clk,
  input  logic                    reset_reset_n,
  input  logic                    mode_wr_i,
  input  logic [1:0]              mode_i,
  input  logic                    banner_wr_i,
  input  logic [AW-1:0]           banner_addr_i,
  input  logic [6:0]              banner_data_i,
  input  logic                    value_valid_i,
  input  logic [4*NUM_DIGITS-1:0] value_i,
  input  logic                    key_n_i,
  output logic [7*NUM_DIGITS-1:0] hex_o,
  output logic [1:0]              mode_o,
  output logic                    key_pulse_o,
  output logic                    heartbeat_o
);

  localparam logic [1:0] MODE_BLANK  = 2'd0;
  localparam logic [1:0] MODE_STATIC = 2'd1;
  localparam logic [1:0] MODE_SCROLL = 2'd2;
  localparam logic [1:0] MODE_HEX    = 2'd3;

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = (HEARTBEAT_DIV > 1) ? $clog2(HEARTBEAT_DIV) : 1;
  localparam logic [AW:0] BANNER_LEN_W = (AW+1)'(BANNER_LEN);

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  logic                    key_meta_q, key_sync_q;
  logic                    key_deb_q, key_deb_d;
  logic [DW-1:0]           deb_cnt_q, deb_cnt_d;
  logic                    key_pulse_q;
  logic                    w_press;
  logic [1:0]              mode_q, mode_d;
  logic                    w_enter_scroll;
  logic [TW-1:0]           tick_q, tick_d;
  logic [AW-1:0]           offset_q, offset_d;
  logic [HW-1:0]           hb_cnt_q, hb_cnt_d;
  logic                    hb_q, hb_d;
  logic [4*NUM_DIGITS-1:0] value_q;
  logic [6:0]              banner_q [BANNER_LEN];
  logic                    w_banner_we;
  logic [7*NUM_DIGITS-1:0] hex_q, hex_d;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      key_meta_q  <= 1'b1;
      key_sync_q  <= 1'b1;
      key_deb_q   <= 1'b1;
      deb_cnt_q   <= '0;
      key_pulse_q <= 1'b0;
      tick_q      <= '0;
      offset_q    <= '0;
      hb_cnt_q    <= '0;
      hb_q        <= 1'b0;
      value_q     <= '0;
      hex_q       <= '1;
    end else begin
      key_meta_q  <= key_n_i;
      key_sync_q  <= key_meta_q;
      key_deb_q   <= key_deb_d;
      deb_cnt_q   <= deb_cnt_d;
      key_pulse_q <= w_press;
      tick_q      <= tick_d;
      offset_q    <= offset_d;
      hb_cnt_q    <= hb_cnt_d;
      hb_q        <= hb_d;
      if (value_valid_i) value_q <= value_i;
      hex_q       <= hex_d;
    end
  end

  // The counter runs only while the synchronised key disagrees with the
  // debounced level; one extra edge past the limit commits the new level.
  always_comb begin
    key_deb_d = key_deb_q;
    deb_cnt_d = '0;
    if (key_sync_q != key_deb_q) begin
      if (deb_cnt_q == DW'(DEBOUNCE_CYCLES)) key_deb_d = key_sync_q;
      else                                   deb_cnt_d = deb_cnt_q + DW'(1);
    end
  end

  assign w_press = key_deb_q & ~key_deb_d;

  // Mode state register
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) mode_q <= MODE_STATIC;
    else                mode_q <= mode_d;
  end

  // Mode next-state: an explicit write overrides a coincident key press
  always_comb begin
    mode_d = mode_q;
    if (mode_wr_i)    mode_d = mode_i;
    else if (w_press) mode_d = mode_q + 2'd1;
  end

  assign w_enter_scroll = (mode_d == MODE_SCROLL) && (mode_q != MODE_SCROLL);

  always_comb begin
    tick_d   = tick_q;
    offset_d = offset_q;
    if (w_enter_scroll) begin
      tick_d   = '0;
      offset_d = '0;
    end else if (mode_q == MODE_SCROLL) begin
      if (tick_q == TW'(TICK_DIV - 1)) begin
        tick_d   = '0;
        offset_d = (offset_q == AW'(BANNER_LEN - 1)) ? '0 : offset_q + AW'(1);
      end else begin
        tick_d = tick_q + TW'(1);
      end
    end
  end

  always_comb begin
    hb_cnt_d = hb_cnt_q + HW'(1);
    hb_d     = hb_q;
    if (hb_cnt_q == HW'(HEARTBEAT_DIV - 1)) begin
      hb_cnt_d = '0;
      hb_d     = ~hb_q;
    end
  end

  assign w_banner_we = banner_wr_i && ({1'b0, banner_addr_i} < BANNER_LEN_W);

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int i = 0; i < BANNER_LEN; i++) banner_q[i] <= 7'h7F;
    end else if (w_banner_we) begin
      banner_q[banner_addr_i] <= banner_data_i;
    end
  end

  // Output decode: digit NUM_DIGITS-1 is leftmost and shows the lowest entry
  for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_digit
    logic [AW:0]   w_sum;
    logic [AW-1:0] w_idx;
    logic [6:0]    w_seg;

    always_comb begin
      w_sum = {1'b0, offset_q} + (AW+1)'(NUM_DIGITS - 1 - d);
      w_idx = AW'((w_sum >= BANNER_LEN_W) ? (w_sum - BANNER_LEN_W) : w_sum);
      case (mode_q)
        MODE_BLANK:  w_seg = 7'h7F;
        MODE_STATIC: w_seg = banner_q[NUM_DIGITS - 1 - d];
        MODE_SCROLL: w_seg = banner_q[w_idx];
        default:     w_seg = hex7(value_q[4*d +: 4]);
      endcase
    end

    assign hex_d[7*d +: 7] = w_seg;
  end

  assign hex_o       = hex_q;
  assign mode_o      = mode_q;
  assign key_pulse_o = key_pulse_q;
  assign heartbeat_o = hb_q;

endmodule
`default_nettype wire

// File: tb/tb_hex_status_display.sv
`default_nettype none
// Bench for hex_status_display: randomized stimulus against a behavioural
// model, plus hand-computed checks for reset, static, hex, scroll and key.
module tb_hex_status_display;
  localparam int ND = 4, BL = 6, TD = 4, DB = 3, HB = 5;

  logic        clk = 1'b0, rst_n = 1'b1;
  logic        mode_wr = 1'b0, banner_wr = 1'b0, value_valid = 1'b0, key_n = 1'b1;
  logic [1:0]  mode_in = '0;
  logic [2:0]  banner_addr = '0;
  logic [6:0]  banner_data = '0;
  logic [15:0] value_in = '0;
  logic [27:0] hex;
  logic [1:0]  mode;
  logic        key_pulse, heartbeat;

  hex_status_display #(.NUM_DIGITS(ND), .BANNER_LEN(BL), .TICK_DIV(TD),
                       .DEBOUNCE_CYCLES(DB), .HEARTBEAT_DIV(HB)) dut (
    .clk_clk(clk), .reset_reset_n(rst_n), .mode_wr_i(mode_wr), .mode_i(mode_in),
    .banner_wr_i(banner_wr), .banner_addr_i(banner_addr), .banner_data_i(banner_data),
    .value_valid_i(value_valid), .value_i(value_in), .key_n_i(key_n),
    .hex_o(hex), .mode_o(mode), .key_pulse_o(key_pulse), .heartbeat_o(heartbeat));

  always #5 clk = ~clk;

  logic [6:0] HEXTAB [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                              7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                              7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
  logic [6:0] pats [6] = '{7'h01, 7'h02, 7'h04, 7'h08, 7'h10, 7'h20};

  int n_checks = 0, n_errors = 0, pulse_cnt = 0;

  // Model state: mode, banner contents, value, edges since reset, scroll entry edge
  int          m_mode, m_edges, m_entry, m_run, m_next, m_off;
  logic [6:0]  m_banner [BL];
  logic [15:0] m_value;
  logic        k1, k2, m_deb, m_press;
  logic [27:0] exp_hex;
  logic [1:0]  exp_mode;
  logic        exp_pulse, exp_hb;

  function automatic logic [27:0] disp(input int md, input int off);
    logic [27:0] r;
    logic [6:0]  s;
    r = '1;
    for (int d = 0; d < ND; d++) begin
      case (md)
        0:       s = 7'h7F;
        1:       s = m_banner[ND-1-d];
        2:       s = m_banner[(off + ND - 1 - d) % BL];
        default: s = HEXTAB[m_value[4*d +: 4]];
      endcase
      r[7*d +: 7] = s;
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 1; m_value = '0; m_edges = 0; m_entry = 0; m_run = 0;
      k1 = 1'b1; k2 = 1'b1; m_deb = 1'b1;
      for (int i = 0; i < BL; i++) m_banner[i] = 7'h7F;
      exp_hex = '1; exp_mode = 2'd1; exp_pulse = 1'b0; exp_hb = 1'b0;
    end else begin
      // Display shows the state that held before this edge
      m_off   = ((m_edges - m_entry) / TD) % BL;
      exp_hex = disp(m_mode, m_off);
      m_edges++;
      // Key must disagree with the debounced level for DB+1 consecutive edges
      m_press = 1'b0;
      if (k2 != m_deb) m_run++; else m_run = 0;
      if (m_run == DB + 1) begin
        m_press = m_deb;
        m_deb   = k2;
        m_run   = 0;
      end
      k2 = k1; k1 = key_n;
      m_next = mode_wr ? int'(mode_in) : (m_press ? (m_mode + 1) % 4 : m_mode);
      if (m_next == 2 && m_mode != 2) m_entry = m_edges;
      m_mode = m_next;
      if (banner_wr && banner_addr < BL) m_banner[banner_addr] = banner_data;
      if (value_valid) m_value = value_in;
      exp_mode  = 2'(m_next);
      exp_pulse = m_press;
      exp_hb    = ((m_edges / HB) % 2) == 1;
    end
  end

  always @(negedge clk) begin
    n_checks++;
    if (hex !== exp_hex || mode !== exp_mode || key_pulse !== exp_pulse || heartbeat !== exp_hb) begin
      n_errors++;
      $display("FAIL model_cmp t=%0t hex=%h exp=%h mode=%0d exp=%0d pulse=%b exp=%b hb=%b exp=%b",
               $time, hex, exp_hex, mode, exp_mode, key_pulse, exp_pulse, heartbeat, exp_hb);
    end
    if (key_pulse === 1'b1) pulse_cnt++;
  end

  task automatic chk(input string name, input logic [27:0] act, input logic [27:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s got=%h expected=%h", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_hex"}, hex, 28'hFFFFFFF);
    chk({name, "_mode"}, 28'(mode), 28'd1);
    chk({name, "_pulse"}, 28'(key_pulse), 28'd0);
    chk({name, "_hb"}, 28'(heartbeat), 28'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int found, p0, key_timer;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk_reset_outputs("reset");
    repeat (4) tick();
    @(negedge clk);
    chk("hb_before_toggle", 28'(heartbeat), 28'd0);
    tick();
    @(negedge clk);
    chk("hb_first_toggle", 28'(heartbeat), 28'd1);

    // Static banner "ECC3"
    for (int i = 0; i < 4; i++) begin
      banner_wr = 1'b1; banner_addr = 3'(i);
      banner_data = (i == 0) ? 7'b0000110 : (i == 3) ? 7'b0110000 : 7'b1000110;
      tick();
    end
    banner_wr = 1'b0;
    tick();
    @(negedge clk);
    chk("static_ecc3", hex, {7'b0000110, 7'b1000110, 7'b1000110, 7'b0110000});

    // HEX mode showing A5F0
    mode_wr = 1'b1; mode_in = 2'd3; value_valid = 1'b1; value_in = 16'hA5F0;
    tick();
    mode_wr = 1'b0; value_valid = 1'b0;
    tick();
    @(negedge clk);
    chk("hex_a5f0", hex, {7'b0001000, 7'b0010010, 7'b0001110, 7'b1000000});

    // Scroll through six distinct entries with wrap
    for (int i = 0; i < 6; i++) begin
      banner_wr = 1'b1; banner_addr = 3'(i); banner_data = pats[i];
      tick();
    end
    banner_wr = 1'b0; mode_wr = 1'b1; mode_in = 2'd2;
    tick();
    mode_wr = 1'b0;
    tick();
    @(negedge clk);
    chk("scroll_left_0", 28'(hex[27:21]), 28'(pats[0]));
    for (int k = 1; k <= 6; k++) begin
      repeat (4) tick();
      @(negedge clk);
      chk($sformatf("scroll_left_%0d", k), 28'(hex[27:21]), 28'(pats[k % 6]));
      if (k == 4) chk("scroll_right_off4", 28'(hex[6:0]), 28'(pats[1]));
    end

    // Debounce: short glitch ignored, held press pulses after 6 cycles
    mode_wr = 1'b1; mode_in = 2'd3;
    tick();
    mode_wr = 1'b0;
    p0 = pulse_cnt;
    key_n = 1'b0; tick(); tick(); key_n = 1'b1;
    repeat (10) tick();
    chk("glitch_no_pulse", 28'(pulse_cnt), 28'(p0));
    key_n = 1'b0;
    found = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      @(negedge clk);
      if (key_pulse === 1'b1) begin
        found = i;
        break;
      end
    end
    chk("press_latency", 28'(found), 28'd6);
    chk("press_mode_wrap", 28'(mode), 28'd0);
    tick();
    @(negedge clk);
    chk("press_blank", hex, 28'hFFFFFFF);
    key_n = 1'b1;
    repeat (12) tick();

    // Key pulse coincident with a mode write: the write wins
    key_n = 1'b0;
    repeat (5) tick();
    mode_wr = 1'b1; mode_in = 2'd2;
    tick();
    mode_wr = 1'b0;
    @(negedge clk);
    chk("collision_mode", 28'(mode), 28'd2);
    chk("collision_pulse", 28'(key_pulse), 28'd1);
    key_n = 1'b1;
    repeat (9) tick();
    #1 rst_n = 1'b0;
    #1 chk_reset_outputs("midscroll_reset");
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Randomized traffic with occasional asynchronous resets
    key_timer = 0;
    for (int c = 0; c < 3000; c++) begin
      banner_wr   = ($urandom_range(3) == 0);
      banner_addr = 3'($urandom_range(7));
      banner_data = 7'($urandom);
      value_valid = ($urandom_range(7) == 0);
      value_in    = 16'($urandom);
      mode_wr     = ($urandom_range(40) == 0);
      mode_in     = 2'($urandom_range(3));
      if (key_timer == 0) begin
        key_n = ~key_n;
        key_timer = $urandom_range(12, 1);
      end else begin
        key_timer--;
      end
      if ($urandom_range(799) == 0) begin
        #1 rst_n = 1'b0;
        #1 chk_reset_outputs("random_reset");
        @(posedge clk);
        #2 rst_n = 1'b1;
      end
      tick();
    end
    mode_wr = 1'b0; banner_wr = 1'b0; value_valid = 1'b0;
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
